// File: rtl/pipe_adder_hs_sv_if.sv
// Operand/result handshake bundle for pipe_adder_hs_sv: operand beat in,
// result beat out, each with its own valid/ready pair.
interface pipe_adder_hs_sv_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipe_adder_hs_sv.sv
// W-bit adder split into W/CW carry-chained register stages with valid/ready
// handshake; back-pressure gates each stage's load enable, flush clears all stages.
module pipe_adder_hs_sv #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  pipe_adder_hs_sv_if.slave bus
);
  localparam int N = W / CW;

  logic [N:0]   rdy;
  logic [N-1:0] vld_p;
  logic [N-1:0] car_p;
  logic [W-1:0] res_p [N];
  logic [W-1:0] a_p   [N];
  logic [W-1:0] b_p   [N];

  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
  endfunction

  // A stage may load when it is empty or its successor is loading this cycle.
  always_comb begin
    rdy    = '0;
    rdy[N] = bus.out_ready;
    for (int k = N - 1; k >= 0; k--) begin
      rdy[k] = !vld_p[k] || rdy[k+1];
    end
  end

  assign bus.in_ready = rdy[0] && !flush;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [CW-1:0] ca;
    logic [CW-1:0] cb;
    logic          ci;
    logic          vin;
    logic [W-1:0]  an;
    logic [W-1:0]  bn;
    logic [W-1:0]  rprev;
    logic [CW:0]   csum;
    logic          vld_q;
    logic          car_q;
    logic [W-1:0]  res_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;

    // Operand bits still to be added are kept right-aligned, so the next
    // chunk always sits in the low CW bits.
    if (k == 0) begin : g_first
      assign ca    = bus.a[CW-1:0];
      assign cb    = bus.b[CW-1:0];
      assign ci    = bus.cin;
      assign vin   = bus.in_valid && bus.in_ready;
      assign an    = bus.a >> CW;
      assign bn    = bus.b >> CW;
      assign rprev = '0;
    end else begin : g_next
      assign ca    = a_p[k-1][CW-1:0];
      assign cb    = b_p[k-1][CW-1:0];
      assign ci    = car_p[k-1];
      assign vin   = vld_p[k-1];
      assign an    = a_p[k-1] >> CW;
      assign bn    = b_p[k-1] >> CW;
      assign rprev = res_p[k-1];
    end

    assign csum = chunk_add(ca, cb, ci);

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_q <= 1'b0;
        car_q <= 1'b0;
        res_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else if (flush) begin
        vld_q <= 1'b0;
        car_q <= 1'b0;
        res_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
      end else if (rdy[k]) begin
        vld_q <= vin;
        car_q <= csum[CW];
        res_q <= rprev | (W'(csum[CW-1:0]) << (k * CW));
        a_q   <= an;
        b_q   <= bn;
      end
    end

    assign vld_p[k] = vld_q;
    assign car_p[k] = car_q;
    assign res_p[k] = res_q;
    assign a_p[k]   = a_q;
    assign b_p[k]   = b_q;
  end

  assign bus.out_valid = vld_p[N-1];
  assign bus.sum       = res_p[N-1];
  assign bus.cout      = car_p[N-1];
endmodule
